// File: rtl/gilbert_tx_scheduler_if.sv
// Frame-request / symbol-strobe bundle between the frame source, the
// gilbert_tx_scheduler and the Gilbert-Elliott channel model.
interface gilbert_tx_scheduler_if #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned CNT_W = 16
);
    logic             channel_state;
    logic             req_valid;
    logic [LEN_W-1:0] req_len;
    logic             req_ready;
    logic             tx_en;
    logic [LEN_W-1:0] tx_idx;
    logic             tx_start;
    logic             busy;
    logic             done_valid;
    logic             done_ok;
    logic [2:0]       done_tries;
    logic [CNT_W-1:0] stat_good;
    logic [CNT_W-1:0] stat_retry;
    logic [CNT_W-1:0] stat_drop;

    modport master (
        input  channel_state, req_valid, req_len,
        output req_ready, tx_en, tx_idx, tx_start, busy,
               done_valid, done_ok, done_tries,
               stat_good, stat_retry, stat_drop
    );

    modport slave (
        output channel_state, req_valid, req_len,
        input  req_ready, tx_en, tx_idx, tx_start, busy,
               done_valid, done_ok, done_tries,
               stat_good, stat_retry, stat_drop
    );
endinterface

// File: rtl/gilbert_tx_scheduler.sv
// Frame transmit scheduler over a Gilbert-Elliott channel with exponential backoff.
// Define GILBERT_SCHED_STATS_EN to enable the saturating statistics counters.
module gilbert_tx_scheduler #(
    parameter int unsigned LEN_W        = 8,
    parameter int unsigned MAX_TRY      = 4,
    parameter int unsigned GOOD_RUN     = 2,
    parameter int unsigned WAIT_MAX     = 64,
    parameter int unsigned BASE_BACKOFF = 4,
    parameter int unsigned BO_CAP       = 3,
    parameter int unsigned CNT_W        = 16
) (
    input logic                   clk,
    input logic                   reset,
    gilbert_tx_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_GOOD, S_SEND, S_BACKOFF, S_DONE, S_DROP
    } state_e;

    localparam int unsigned RUN_W  = $clog2(GOOD_RUN + 1);
    localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);
    localparam int unsigned BO_MAX = BASE_BACKOFF << BO_CAP;
    localparam int unsigned BO_W   = $clog2(BO_MAX + 1);

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(GOOD_RUN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
    localparam logic [2:0]        TRY_LAST  = 3'(MAX_TRY);
    localparam logic [2:0]        CAP_SH    = 3'(BO_CAP);
    localparam logic [BO_W-1:0]   BO_BASE   = BO_W'(BASE_BACKOFF);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [2:0]        try_q, try_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [BO_W-1:0]   bo_q, bo_d;
    logic              fail;
    logic              drop_en;
    logic [2:0]        try_m1;
    logic [2:0]        bo_sh;
    logic [BO_W-1:0]   bo_len;

    // Shift saturates at BO_CAP and is applied at backoff-counter width.
    assign try_m1 = try_q - 3'd1;
    assign bo_sh  = (try_m1 > CAP_SH) ? CAP_SH : try_m1;
    assign bo_len = BO_BASE << bo_sh;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            try_q   <= '0;
            run_q   <= '0;
            wait_q  <= '0;
            bo_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            try_q   <= try_d;
            run_q   <= run_d;
            wait_q  <= wait_d;
            bo_q    <= bo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        try_d   = try_q;
        run_d   = run_q;
        wait_d  = wait_q;
        bo_d    = bo_q;
        fail    = 1'b0;
        drop_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    len_d = bus.req_len;
                    try_d = '0;
                    if (bus.req_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_GOOD;
                        try_d   = 3'd1;
                        run_d   = '0;
                        wait_d  = '0;
                        idx_d   = '0;
                    end
                end
            end
            S_WAIT_GOOD: begin
                if (bus.channel_state && run_q == RUN_LAST) begin
                    state_d = S_SEND;
                    idx_d   = '0;
                end else begin
                    run_d = bus.channel_state ? run_q + RUN_W'(1) : '0;
                    if (wait_q == WAIT_LAST) fail = 1'b1;
                    else wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_SEND: begin
                if (!bus.channel_state) fail = 1'b1;
                else if (idx_q == len_q - LEN_W'(1)) state_d = S_DONE;
                else idx_d = idx_q + LEN_W'(1);
            end
            S_BACKOFF: begin
                if (bo_q <= BO_W'(1)) begin
                    state_d = S_WAIT_GOOD;
                    try_d   = try_q + 3'd1;
                    run_d   = '0;
                    wait_d  = '0;
                    idx_d   = '0;
                end else begin
                    bo_d = bo_q - BO_W'(1);
                end
            end
            S_DONE, S_DROP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (fail) begin
            if (try_q == TRY_LAST) begin
                state_d = S_DROP;
                drop_en = 1'b1;
            end else begin
                state_d = S_BACKOFF;
                bo_d    = bo_len;
            end
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE) && !reset;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.tx_en      = (state_q == S_SEND);
    assign bus.tx_idx     = (state_q == S_SEND) ? idx_q : '0;
    assign bus.tx_start   = (state_q == S_SEND) && (idx_q == '0);
    assign bus.done_valid = (state_q == S_DONE) || (state_q == S_DROP);
    assign bus.done_ok    = (state_q == S_DONE);
    assign bus.done_tries = bus.done_valid ? try_q : '0;

`ifdef GILBERT_SCHED_STATS_EN
    logic [CNT_W-1:0] good_q, retry_q, drop_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            good_q  <= '0;
            retry_q <= '0;
            drop_q  <= '0;
        end else begin
            if (bus.channel_state && good_q != '1) good_q <= good_q + CNT_W'(1);
            if (fail && retry_q != '1) retry_q <= retry_q + CNT_W'(1);
            if (drop_en && drop_q != '1) drop_q <= drop_q + CNT_W'(1);
        end
    end

    assign bus.stat_good  = good_q;
    assign bus.stat_retry = retry_q;
    assign bus.stat_drop  = drop_q;
`else
    assign bus.stat_good  = '0;
    assign bus.stat_retry = '0;
    assign bus.stat_drop  = '0;
`endif
endmodule

// File: tb/tb_gilbert_tx_scheduler.sv
// Randomized self-checking bench for gilbert_tx_scheduler against a per-attempt
// behavioural model of the expected strobe/completion timeline.
module tb_gilbert_tx_scheduler;
    localparam int LEN_W        = 8;
    localparam int MAX_TRY      = 4;
    localparam int GOOD_RUN     = 2;
    localparam int WAIT_MAX     = 64;
    localparam int BASE_BACKOFF = 4;
    localparam int BO_CAP       = 3;
    localparam int CNT_W        = 16;
    localparam int MAXC         = 1024;

    logic clk = 1'b0;
    logic reset;

    gilbert_tx_scheduler_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    gilbert_tx_scheduler #(
        .LEN_W(LEN_W), .MAX_TRY(MAX_TRY), .GOOD_RUN(GOOD_RUN),
        .WAIT_MAX(WAIT_MAX), .BASE_BACKOFF(BASE_BACKOFF),
        .BO_CAP(BO_CAP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Channel value sampled at the edge that ends cycle c (accept edge ends cycle 0).
    bit ch [MAXC];
    bit e_en [MAXC];
    int e_idx [MAXC];
    int done_t;
    bit e_ok;
    int e_tries;
    int e_fail;

    int exp_good = 0;
    int exp_retry = 0;
    int exp_drop = 0;

    always @(posedge clk) begin
        if (reset) exp_good <= 0;
        else if (bus.channel_state) exp_good <= exp_good + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic check_stats();
`ifdef GILBERT_SCHED_STATS_EN
        check_val("stat_good", 32'(bus.stat_good), 32'(exp_good));
        check_val("stat_retry", 32'(bus.stat_retry), 32'(exp_retry));
        check_val("stat_drop", 32'(bus.stat_drop), 32'(exp_drop));
`else
        check_val("stat_good", 32'(bus.stat_good), 32'd0);
        check_val("stat_retry", 32'(bus.stat_retry), 32'd0);
        check_val("stat_drop", 32'(bus.stat_drop), 32'd0);
`endif
    endtask

    // Timeline model: walk attempts, each a wait-for-run search then a send run.
    task automatic build_model(input int len);
        int t, tries, s, run, failed_at, sh;
        bit fin;
        for (int c = 0; c < MAXC; c++) begin
            e_en[c] = 1'b0;
            e_idx[c] = 0;
        end
        e_fail = 0;
        if (len == 0) begin
            done_t = 1; e_ok = 1'b1; e_tries = 0;
            return;
        end
        t = 1; tries = 0; fin = 1'b0;
        while (!fin) begin
            tries++;
            s = -1; run = 0;
            for (int k = 0; k < WAIT_MAX && s < 0; k++) begin
                run = ch[t+k] ? run + 1 : 0;
                if (run == GOOD_RUN) s = t + k + 1;
            end
            failed_at = -1;
            if (s < 0) begin
                failed_at = t + WAIT_MAX;
            end else begin
                for (int i = 0; i < len && failed_at < 0; i++) begin
                    e_en[s+i] = 1'b1;
                    e_idx[s+i] = i;
                    if (!ch[s+i]) failed_at = s + i + 1;
                end
                if (failed_at < 0) begin
                    done_t = s + len; e_ok = 1'b1; fin = 1'b1;
                end
            end
            if (!fin) begin
                e_fail++;
                if (tries == MAX_TRY) begin
                    done_t = failed_at; e_ok = 1'b0; fin = 1'b1;
                end else begin
                    sh = (tries - 1 < BO_CAP) ? tries - 1 : BO_CAP;
                    t = failed_at + (BASE_BACKOFF << sh);
                end
            end
        end
        e_tries = tries;
    endtask

    // mode: 0 all good, 1 all bad, 2 random 50%, 3 random 80%, 4 one bad sample at idx 2
    task automatic run_frame(input int len, input int mode, input bit hold);
        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                0: ch[c] = 1'b1;
                1: ch[c] = 1'b0;
                2: ch[c] = 1'($urandom_range(0, 1));
                3: ch[c] = ($urandom_range(0, 9) < 8);
                default: ch[c] = (c != GOOD_RUN + 1 + 2);
            endcase
        end
        build_model(len);
        @(negedge clk);
        check_val("idle_ready", 32'(bus.req_ready), 32'd1);
        check_val("idle_busy", 32'(bus.busy), 32'd0);
        check_val("idle_done", 32'(bus.done_valid), 32'd0);
        check_stats();
        bus.req_valid = 1'b1;
        bus.req_len = LEN_W'(len);
        bus.channel_state = ch[0];
        for (int c = 1; c <= done_t; c++) begin
            @(negedge clk);
            check_val("tx_en", 32'(bus.tx_en), 32'(e_en[c]));
            if (e_en[c]) begin
                check_val("tx_idx", 32'(bus.tx_idx), 32'(e_idx[c]));
                check_val("tx_start", 32'(bus.tx_start), 32'(e_idx[c] == 0));
            end else begin
                check_val("tx_start_idle", 32'(bus.tx_start), 32'd0);
            end
            check_val("busy", 32'(bus.busy), 32'd1);
            check_val("req_ready_busy", 32'(bus.req_ready), 32'd0);
            check_val("done_valid", 32'(bus.done_valid), 32'(c == done_t));
            if (c == done_t) begin
                check_val("done_ok", 32'(bus.done_ok), 32'(e_ok));
                check_val("done_tries", 32'(bus.done_tries), 32'(e_tries));
            end
            bus.req_valid = hold;
            bus.req_len = LEN_W'($urandom_range(0, 255));
            bus.channel_state = ch[c];
        end
        exp_retry += e_fail;
        if (!e_ok) exp_drop++;
    endtask

    task automatic reset_mid_send();
        @(negedge clk);
        check_val("rst_pre_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_len = LEN_W'(5);
        bus.channel_state = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
        check_val("rst_pre_en", 32'(bus.tx_en), 32'd1);
        check_val("rst_pre_idx", 32'(bus.tx_idx), 32'd1);
        reset = 1'b1;
        bus.channel_state = 1'b0;
        @(negedge clk);
        check_val("rst_tx_en", 32'(bus.tx_en), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done_valid), 32'd0);
        check_val("rst_ready_held", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        exp_retry = 0;
        exp_drop = 0;
        @(negedge clk);
        check_val("rst_ready_after", 32'(bus.req_ready), 32'd1);
        check_val("rst_done_after", 32'(bus.done_valid), 32'd0);
        check_val("rst_tx_en_after", 32'(bus.tx_en), 32'd0);
        check_stats();
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_len = '0;
        bus.channel_state = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("reset_ready", 32'(bus.req_ready), 32'd0);
            check_val("reset_busy", 32'(bus.busy), 32'd0);
            check_val("reset_tx_en", 32'(bus.tx_en), 32'd0);
            check_val("reset_done", 32'(bus.done_valid), 32'd0);
            check_val("reset_tries", 32'(bus.done_tries), 32'd0);
        end
        reset = 1'b0;

        run_frame(5, 0, 1'b0);
        run_frame(5, 4, 1'b0);
        run_frame(3, 1, 1'b0);
        run_frame(0, 0, 1'b0);
        run_frame(4, 0, 1'b1);
        run_frame(2, 3, 1'b1);
        run_frame(0, 2, 1'b0);
        reset_mid_send();
        for (int n = 0; n < 40; n++) begin
            run_frame(int'($urandom_range(0, 12)), int'($urandom_range(0, 4)),
                      1'($urandom_range(0, 1)));
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_val("final_idle", 32'(bus.busy), 32'd0);
        check_stats();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
